// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared state encoding, op encoding and address-range
// constants for the memory access controller.
package mem_access_pkg;

  // State encoding, 3 bits
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    STROBE = ST_STROBE,
    HOLD   = ST_HOLD,
    RESP   = ST_RESP
  } state_t;

  // Memory decodes addr[ADDR_MSB_LIMIT-1:0]; anything above is out of range
  localparam int ADDR_MSB_LIMIT = 12;

  // Op encoding (req_write value)
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // True when the word address has bits set above the memory window
  function automatic logic addr_out_of_range(input logic [31:0] addr);
    return addr[31:ADDR_MSB_LIMIT] != '0;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake plus the level-sensitive
// memory bus. slave = controller side, master = datapath/memory side.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_ren, mem_wen, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_ren, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_access_ctrl_strobe_timer.sv
// strobe_timer: 4-bit loadable down-counter that sets the strobe dwell.
// load has priority over en; done is high while the count is zero.
module strobe_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       en,
  output logic       done
);
  logic [3:0] count_reg;

  // Count down from the loaded value, saturating at zero
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != 4'd0)) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign done = (count_reg == 4'd0);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding initiator for a level-sensitive
// single-port memory. Sequences SETUP -> STROBE -> HOLD so addr/din are
// stable around every strobe, then returns a completion.
// Optional feature macro: MEM_ACCESS_RANGE_CHECK_EN (reject addr[31:12]!=0).
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int STROBE_CYCLES = 1   // legal range 1..15
) (
  input  logic              clock,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus
);

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  localparam bit RANGE_CHECK_EN = 1'b1;
`else
  localparam bit RANGE_CHECK_EN = 1'b0;
`endif

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_t      state_reg;
  logic        op_reg;
  logic        mem_ren_reg;
  logic        mem_wen_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_din_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;
  logic        timer_done;

  // Dwell counter is loaded in SETUP and runs during STROBE
  strobe_timer u_strobe_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (state_reg == SETUP),
    .load_value (STROBE_LOAD),
    .en         (state_reg == STROBE),
    .done       (timer_done)
  );

  // Access sequencer with registered strobes, bus and response outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
      op_reg         <= OP_READ;
      mem_ren_reg    <= 1'b0;
      mem_wen_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_din_reg    <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
            if (RANGE_CHECK_EN && addr_out_of_range(bus.req_addr)) begin
              // Rejected: memory bus is left untouched
              resp_err_reg   <= 1'b1;
              resp_valid_reg <= 1'b1;
              state_reg      <= RESP;
            end else begin
              mem_addr_reg <= bus.req_addr;
              mem_din_reg  <= bus.req_wdata;
              op_reg       <= bus.req_write;
              state_reg    <= SETUP;
            end
          end
        end
        SETUP: begin
          mem_ren_reg <= (op_reg == OP_READ);
          mem_wen_reg <= (op_reg == OP_WRITE);
          state_reg   <= STROBE;
        end
        STROBE: begin
          if (timer_done) begin
            // Read data is sampled while ren is still high
            mem_ren_reg <= 1'b0;
            mem_wen_reg <= 1'b0;
            if (op_reg == OP_READ) begin
              resp_rdata_reg <= bus.mem_dout;
            end
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = reset && (state_reg == IDLE);
  assign bus.mem_ren    = mem_ren_reg;
  assign bus.mem_wen    = mem_wen_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_din    = mem_din_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl with two instances
// (STROBE_CYCLES=1 and 3) each driving a small level-sensitive memory model.
// Honors MEM_ACCESS_RANGE_CHECK_EN for the out-of-range request case.
module tb_mem_access_ctrl;

  logic clock;
  logic reset;
  logic init_mem;
  bit   mon_en;

  int checks;
  int errors;

  // Index 0 -> STROBE_CYCLES=1 instance, index 1 -> STROBE_CYCLES=3
  logic [1:0]  rq_valid;
  logic [1:0]  rq_write;
  logic [31:0] rq_addr  [2];
  logic [31:0] rq_wdata [2];
  logic [1:0]  rs_ready;
  logic [1:0]  rq_ready;
  logic [1:0]  rs_valid;
  logic [1:0]  rs_err;
  logic [31:0] rs_rdata [2];
  logic [1:0]  m_ren;
  logic [1:0]  m_wen;
  logic [31:0] m_addr   [2];
  logic [31:0] m_din    [2];

  logic [31:0] mem0 [4096];
  logic [31:0] mem1 [4096];
  logic [31:0] shadow [4096];

  mem_access_ctrl_if bus_a ();
  mem_access_ctrl_if bus_b ();

  mem_access_ctrl #(.STROBE_CYCLES(1)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  mem_access_ctrl #(.STROBE_CYCLES(3)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  assign bus_a.req_valid  = rq_valid[0];
  assign bus_a.req_write  = rq_write[0];
  assign bus_a.req_addr   = rq_addr[0];
  assign bus_a.req_wdata  = rq_wdata[0];
  assign bus_a.resp_ready = rs_ready[0];
  assign bus_b.req_valid  = rq_valid[1];
  assign bus_b.req_write  = rq_write[1];
  assign bus_b.req_addr   = rq_addr[1];
  assign bus_b.req_wdata  = rq_wdata[1];
  assign bus_b.resp_ready = rs_ready[1];

  assign rq_ready = {bus_b.req_ready, bus_a.req_ready};
  assign rs_valid = {bus_b.resp_valid, bus_a.resp_valid};
  assign rs_err   = {bus_b.resp_err, bus_a.resp_err};
  assign m_ren    = {bus_b.mem_ren, bus_a.mem_ren};
  assign m_wen    = {bus_b.mem_wen, bus_a.mem_wen};
  assign rs_rdata[0] = bus_a.resp_rdata;
  assign rs_rdata[1] = bus_b.resp_rdata;
  assign m_addr[0]   = bus_a.mem_addr;
  assign m_addr[1]   = bus_b.mem_addr;
  assign m_din[0]    = bus_a.mem_din;
  assign m_din[1]    = bus_b.mem_din;

  // Read data only valid during a pure read strobe; otherwise a marker value
  assign bus_a.mem_dout = (bus_a.mem_ren && !bus_a.mem_wen) ? mem0[bus_a.mem_addr[11:0]] : 32'hBAD0BAD0;
  assign bus_b.mem_dout = (bus_b.mem_ren && !bus_b.mem_wen) ? mem1[bus_b.mem_addr[11:0]] : 32'hBAD0BAD0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory models: preload a known pattern, write while wen is high
  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= 32'hC0DE0000 | i;
        mem1[i] <= 32'hC0DE0000 | i;
      end
    end else begin
      if (bus_a.mem_wen) mem0[bus_a.mem_addr[11:0]] <= bus_a.mem_din;
      if (bus_b.mem_wen) mem1[bus_b.mem_addr[11:0]] <= bus_b.mem_din;
    end
  end

  // Bus monitor: strobe cycle totals, ren&wen overlap, addr/din stability
  int          ren_tot [2];
  int          wen_tot [2];
  int          both_viol;
  int          addr_viol;
  logic        s1 [2];
  logic [31:0] a1 [2];
  logic [31:0] d1 [2];

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (m_ren[i]) ren_tot[i]++;
      if (m_wen[i]) wen_tot[i]++;
      if (m_ren[i] && m_wen[i]) both_viol++;
      if (mon_en && (m_ren[i] || m_wen[i] || s1[i]) &&
          (m_addr[i] != a1[i] || m_din[i] != d1[i])) addr_viol++;
      s1[i] = m_ren[i] | m_wen[i];
      a1[i] = m_addr[i];
      d1[i] = m_din[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full request/response transaction on instance b
  task automatic do_req(input int b, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int rens, output int wens);
    int r0;
    int w0;
    @(negedge clock);
    check("req_ready_idle", {31'd0, rq_ready[b]}, 32'd1);
    r0 = ren_tot[b];
    w0 = wen_tot[b];
    rq_valid[b] = 1'b1;
    rq_write[b] = w;
    rq_addr[b]  = a;
    rq_wdata[b] = d;
    @(posedge clock);
    @(negedge clock);
    rq_valid[b] = 1'b0;
    lat = 0;
    while (!rs_valid[b] && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    if (!rs_valid[b]) check("resp_timeout", {31'd0, rs_valid[b]}, 32'd1);
    rdata = rs_rdata[b];
    err   = rs_err[b];
    rs_ready[b] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rs_ready[b] = 1'b0;
    check("resp_valid_drop", {31'd0, rs_valid[b]}, 32'd0);
    rens = ren_tot[b] - r0;
    wens = wen_tot[b] - w0;
    $display("txn inst%0d %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d ren=%0d wen=%0d",
             b, w ? "WR" : "RD", a, d, rdata, err, lat, rens, wens);
  endtask

  logic [31:0] rdata;
  logic        err;
  int          lat;
  int          rens;
  int          wens;
  int          r0;

  initial begin
    checks = 0;
    errors = 0;
    rq_valid = '0;
    rq_write = '0;
    rs_ready = '0;
    rq_addr[0] = '0; rq_addr[1] = '0;
    rq_wdata[0] = '0; rq_wdata[1] = '0;
    for (int i = 0; i < 4096; i++) shadow[i] = 32'hC0DE0000 | i;
    reset = 1'b0;
    init_mem = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", {31'd0, rq_ready[0]}, 32'd0);
    check("rst_mem_ren", {31'd0, m_ren[0]}, 32'd0);
    check("rst_mem_wen", {31'd0, m_wen[0]}, 32'd0);
    check("rst_mem_addr", m_addr[0], 32'd0);
    check("rst_mem_din", m_din[0], 32'd0);
    check("rst_resp_valid", {31'd0, rs_valid[0]}, 32'd0);
    check("rst_resp_rdata", rs_rdata[0], 32'd0);
    check("rst_resp_err", {31'd0, rs_err[0]}, 32'd0);
    init_mem = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_req_ready", {31'd0, rq_ready[0]}, 32'd1);
    mon_en = 1'b1;

    // Write then read, default dwell
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, rdata, err, lat, rens, wens);
    shadow[16'h10] = 32'hDEADBEEF;
    check("wr10_lat", lat, 32'd3);
    check("wr10_wen_cycles", wens, 32'd1);
    check("wr10_ren_cycles", rens, 32'd0);
    check("wr10_rdata", rdata, 32'd0);
    check("wr10_err", {31'd0, err}, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, rdata, err, lat, rens, wens);
    check("rd10_rdata", rdata, 32'hDEADBEEF);
    check("rd10_err", {31'd0, err}, 32'd0);
    check("rd10_lat", lat, 32'd3);
    check("rd10_ren_cycles", rens, 32'd1);

    // More directed patterns including top of the window
    do_req(0, 1'b1, 32'h123, 32'h12345678, rdata, err, lat, rens, wens);
    shadow[12'h123] = 32'h12345678;
    do_req(0, 1'b1, 32'hFFF, 32'hA5A5A5A5, rdata, err, lat, rens, wens);
    shadow[12'hFFF] = 32'hA5A5A5A5;
    do_req(0, 1'b0, 32'hFFF, 32'h0, rdata, err, lat, rens, wens);
    check("rdFFF_rdata", rdata, 32'hA5A5A5A5);
    do_req(0, 1'b0, 32'h7, 32'h0, rdata, err, lat, rens, wens);
    check("rd7_preload", rdata, 32'hC0DE0007);

    // Backpressure: hold resp_ready low 10 cycles with a new request pending
    @(negedge clock);
    rq_valid[0] = 1'b1; rq_write[0] = 1'b0; rq_addr[0] = 32'h123;
    @(posedge clock);
    @(negedge clock);
    rq_valid[0] = 1'b0;
    lat = 0;
    while (!rs_valid[0] && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    check("bp_lat", lat, 32'd3);
    rq_valid[0] = 1'b1; rq_write[0] = 1'b0; rq_addr[0] = 32'hFFF;
    r0 = ren_tot[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("bp_resp_valid", {31'd0, rs_valid[0]}, 32'd1);
      check("bp_resp_rdata", rs_rdata[0], 32'h12345678);
      check("bp_req_ready", {31'd0, rq_ready[0]}, 32'd0);
    end
    check("bp_no_strobe", ren_tot[0] - r0, 32'd0);
    rs_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rs_ready[0] = 1'b0;
    check("bp_consumed", {31'd0, rs_valid[0]}, 32'd0);
    check("bp_ready_after", {31'd0, rq_ready[0]}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    rq_valid[0] = 1'b0;
    check("bp_accepted", {31'd0, rq_ready[0]}, 32'd0);
    lat = 0;
    while (!rs_valid[0] && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    check("bp_next_lat", lat, 32'd3);
    check("bp_next_rdata", rs_rdata[0], 32'hA5A5A5A5);
    rs_ready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rs_ready[0] = 1'b0;
    $display("txn inst0 RD addr=00000fff backpressured-follow-on done");

    // Reset during a write strobe
    @(negedge clock);
    rq_valid[0] = 1'b1; rq_write[0] = 1'b1; rq_addr[0] = 32'h20; rq_wdata[0] = 32'h55;
    @(posedge clock);
    @(negedge clock);
    rq_valid[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rs_wen_before", {31'd0, m_wen[0]}, 32'd1);
    mon_en = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rs_mem_wen", {31'd0, m_wen[0]}, 32'd0);
    check("rs_mem_ren", {31'd0, m_ren[0]}, 32'd0);
    check("rs_mem_addr", m_addr[0], 32'd0);
    check("rs_mem_din", m_din[0], 32'd0);
    check("rs_resp_valid", {31'd0, rs_valid[0]}, 32'd0);
    check("rs_resp_rdata", rs_rdata[0], 32'd0);
    check("rs_resp_err", {31'd0, rs_err[0]}, 32'd0);
    check("rs_req_ready", {31'd0, rq_ready[0]}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rs_req_ready_rel", {31'd0, rq_ready[0]}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("rs_no_resp", {31'd0, rs_valid[0]}, 32'd0);
    end
    mon_en = 1'b1;
    $display("txn inst0 WR addr=00000020 aborted by reset");

    // Out-of-window address
    do_req(0, 1'b0, 32'h0000_1000, 32'h0, rdata, err, lat, rens, wens);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    check("oor_lat", lat, 32'd0);
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_rdata", rdata, 32'd0);
    check("oor_ren_cycles", rens, 32'd0);
`else
    check("oor_lat", lat, 32'd3);
    check("oor_err", {31'd0, err}, 32'd0);
    check("oor_rdata", rdata, 32'hC0DE0000);
    check("oor_ren_cycles", rens, 32'd1);
`endif

    // STROBE_CYCLES=3 instance
    do_req(1, 1'b0, 32'h3FF, 32'h0, rdata, err, lat, rens, wens);
    check("s3_rd_lat", lat, 32'd5);
    check("s3_rd_ren_cycles", rens, 32'd3);
    check("s3_rd_rdata", rdata, 32'hC0DE03FF);
    do_req(1, 1'b1, 32'h3FF, 32'h0BADF00D, rdata, err, lat, rens, wens);
    check("s3_wr_lat", lat, 32'd5);
    check("s3_wr_wen_cycles", wens, 32'd3);
    do_req(1, 1'b0, 32'h3FF, 32'h0, rdata, err, lat, rens, wens);
    check("s3_rdback", rdata, 32'h0BADF00D);

    // Random traffic against a shadow memory
    for (int n = 0; n < 1000; n++) begin
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 15);
      d = $urandom;
      do_req(0, w, a, d, rdata, err, lat, rens, wens);
      check("rnd_lat", lat, 32'd3);
      if (w) begin
        shadow[a[11:0]] = d;
        check("rnd_wr_wens", wens, 32'd1);
        check("rnd_wr_rdata", rdata, 32'd0);
      end else begin
        check("rnd_rd_rens", rens, 32'd1);
        check("rnd_rd_rdata", rdata, shadow[a[11:0]]);
      end
    end

    check("ren_wen_overlap", both_viol, 32'd0);
    check("addr_din_stability", addr_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
